spi_slave_clk_gen: RTL and testbench

Slave-side timing generator for the SPI core. It synchronises the external SCK and SS_n pins into the system clock domain and decodes them by CPOL/CPHA. It emits one-cycle S_Shift_clk and S_Sample_clk strobes and the S_BaudRate transfer-active level, which the master/slave selector forwards to the shift register and control logic when MSTR=0. It also counts bits, flags byte completion and reports frames aborted by early SS_n release.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_sync_edge.sv | 48 ++++
 rtl/spi_slave_clk_gen.sv | 167 ++++++++++++++++
 tb/tb_spi_slave_clk_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave timing path.
// Mode packing and edge-role helpers keep the CPOL/CPHA decode in one place.
package spi_pkg;

  localparam int DEF_BITS        = 8;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } mode_t;

  // Leading edge leaves the idle level, trailing edge returns to it.
  function automatic logic lead_edge(input mode_t m, input logic rise, input logic fall);
    return m.cpol ? fall : rise;
  endfunction

  function automatic logic trail_edge(input mode_t m, input logic rise, input logic fall);
    return m.cpol ? rise : fall;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus a history flop for edge detection.
// Reset level is RESET_VAL, optionally inverted at run time by rst_flip (used for SCK vs CPOL).
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_flip,
  input  logic pin,
  output logic sync_level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              hist_q;
  logic              hist_d;
  logic              rst_level;

  assign rst_level = RESET_VAL ^ rst_flip;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign sync_d[gi] = pin;
    end else begin : g_next
      assign sync_d[gi] = sync_q[gi-1];
    end
  end

  assign hist_d = sync_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{rst_level}};
      hist_q <= rst_level;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign sync_level = sync_q[STAGES-1];
  assign rise       = sync_level & ~hist_q;
  assign fall       = ~sync_level & hist_q;

endmodule

// File: rtl/spi_slave_clk_gen.sv
// Slave-side SPI timing generator: synchronises SCK/SS_n, decodes CPOL/CPHA into
// registered shift/sample strobes, counts bits and flags byte completion and aborts.
module spi_slave_clk_gen
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int BITS        = DEF_BITS,
  localparam int CW         = $clog2(BITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          SPE,
  input  logic          MSTR,
  input  logic          CPOL,
  input  logic          CPHA,
  input  logic          SCK,
  input  logic          SS_n,
  output logic          S_Shift_clk,
  output logic          S_Sample_clk,
  output logic          S_BaudRate,
  output logic [CW-1:0] bit_cnt,
  output logic          byte_done,
  output logic          frame_abort
);

  localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BITS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  mode_t  mode;
  logic   enabled;
  logic   unused_sck_level;
  logic   sck_rise, sck_fall;
  logic   ss_level, ss_rise, ss_fall;
  logic   lead, trail;
  logic   sample_edge, shift_edge;

  state_e        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          shift_q, shift_d;
  logic          sample_q, sample_d;
  logic          baud_q, baud_d;
  logic          done_q, done_d;
  logic          abort_q, abort_d;

  assign mode    = '{cpol: CPOL, cpha: CPHA};
  assign enabled = SPE & ~MSTR;

  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sck_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_flip   (CPOL),
    .pin        (SCK),
    .sync_level (unused_sck_level),
    .rise       (sck_rise),
    .fall       (sck_fall)
  );

  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_ss_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_flip   (1'b0),
    .pin        (SS_n),
    .sync_level (ss_level),
    .rise       (ss_rise),
    .fall       (ss_fall)
  );

  // SCK activity only matters while the slave is selected.
  assign lead        = lead_edge(mode, sck_rise, sck_fall) & ~ss_level;
  assign trail       = trail_edge(mode, sck_rise, sck_fall) & ~ss_level;
  assign sample_edge = mode.cpha ? trail : lead;
  assign shift_edge  = mode.cpha ? lead : trail;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = 1'b0;
    sample_d  = 1'b0;
    done_d    = 1'b0;
    abort_d   = 1'b0;

    if (!enabled) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = '0;
          if (ss_fall) begin
            state_d = ACTIVE;
            shift_d = ~mode.cpha;
          end
        end
        ACTIVE: begin
          // ss_rise wins over any SCK edge seen in the same cycle.
          if (ss_rise) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            abort_d   = (bit_cnt_q != '0) && (bit_cnt_q < CNT_FULL);
          end else if (sample_edge) begin
            sample_d  = 1'b1;
            bit_cnt_d = bit_cnt_q + CNT_ONE;
            if (bit_cnt_q == CNT_LAST) begin
              done_d  = 1'b1;
              state_d = DONE;
            end
          end else if (shift_edge) begin
            shift_d = 1'b1;
          end
        end
        DONE: begin
          bit_cnt_d = '0;
          if (ss_rise) begin
            state_d = IDLE;
          end else if (sample_edge) begin
            state_d   = ACTIVE;
            sample_d  = 1'b1;
            bit_cnt_d = CNT_ONE;
          end else if (shift_edge) begin
            shift_d = 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end
      endcase
    end

    baud_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= 1'b0;
      sample_q  <= 1'b0;
      baud_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      baud_q    <= baud_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

  assign S_Shift_clk  = shift_q;
  assign S_Sample_clk = sample_q;
  assign S_BaudRate   = baud_q;
  assign bit_cnt      = bit_cnt_q;
  assign byte_done    = done_q;
  assign frame_abort  = abort_q;

endmodule

// File: tb/tb_spi_slave_clk_gen.sv
// Randomised bench: pin activity is replayed through a delayed-pin frame model
// (total sample count per frame) and every output is compared each cycle.
module tb_spi_slave_clk_gen;

  localparam int BITS = 8;
  localparam int SYNC = 2;
  localparam int CW   = $clog2(BITS + 1);
  localparam int MAXC = 40000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          SPE = 1'b0;
  logic          MSTR = 1'b0;
  logic          CPOL = 1'b0;
  logic          CPHA = 1'b0;
  logic          SCK = 1'b0;
  logic          SS_n = 1'b1;
  logic          S_Shift_clk, S_Sample_clk, S_BaudRate, byte_done, frame_abort;
  logic [CW-1:0] bit_cnt;

  spi_slave_clk_gen #(.SYNC_STAGES(SYNC), .BITS(BITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .SPE          (SPE),
    .MSTR         (MSTR),
    .CPOL         (CPOL),
    .CPHA         (CPHA),
    .SCK          (SCK),
    .SS_n         (SS_n),
    .S_Shift_clk  (S_Shift_clk),
    .S_Sample_clk (S_Sample_clk),
    .S_BaudRate   (S_BaudRate),
    .bit_cnt      (bit_cnt),
    .byte_done    (byte_done),
    .frame_abort  (frame_abort)
  );

  always #5 clk = ~clk;

  // Pin values as captured by the first synchroniser flop at each clock edge.
  bit sck_h [MAXC];
  bit ss_h  [MAXC];
  int cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  bit in_frame = 1'b0;
  int nsamp    = 0;

  int f_samp = 0, f_done = 0, f_abort = 0, f_shift = 0;
  int frame_no = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step();
    bit sn, sp, qn, qp, s_rise, s_fall, q_rise, q_fall, lead, trail;
    int e_shift, e_samp, e_baud, e_cnt, e_done, e_abort;
    e_shift = 0; e_samp = 0; e_baud = 0; e_cnt = 0; e_done = 0; e_abort = 0;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1);
    end
    sck_h[cyc] = SCK;
    ss_h[cyc]  = SS_n;
    if (!rst_n) begin
      for (int i = cyc - SYNC; i <= cyc; i++) begin
        if (i >= 0) begin
          sck_h[i] = CPOL;
          ss_h[i]  = 1'b1;
        end
      end
      in_frame = 1'b0;
      nsamp    = 0;
    end else begin
      sn = sck_h[cyc-SYNC]; sp = sck_h[cyc-SYNC-1];
      qn = ss_h[cyc-SYNC];  qp = ss_h[cyc-SYNC-1];
      s_rise = sn && !sp;  s_fall = !sn && sp;
      q_rise = qn && !qp;  q_fall = !qn && qp;
      lead   = CPOL ? s_fall : s_rise;
      trail  = CPOL ? s_rise : s_fall;
      if (!(SPE && !MSTR)) begin
        in_frame = 1'b0;
        nsamp    = 0;
      end else if (!in_frame) begin
        if (q_fall) begin
          in_frame = 1'b1;
          nsamp    = 0;
          e_shift  = !CPHA;
        end
      end else if (q_rise) begin
        e_abort  = ((nsamp % BITS) != 0);
        in_frame = 1'b0;
        nsamp    = 0;
      end else if (CPHA ? trail : lead) begin
        nsamp++;
        e_samp = 1;
        e_done = ((nsamp % BITS) == 0);
      end else if (CPHA ? lead : trail) begin
        e_shift = 1;
      end
      e_baud = in_frame;
      e_cnt  = !in_frame ? 0 : (e_done ? BITS : nsamp % BITS);
    end
    check("shift",  S_Shift_clk,  e_shift);
    check("sample", S_Sample_clk, e_samp);
    check("baud",   S_BaudRate,   e_baud);
    check("bitcnt", bit_cnt,      e_cnt);
    check("done",   byte_done,    e_done);
    check("abort",  frame_abort,  e_abort);
    check("excl",   S_Shift_clk & S_Sample_clk, 0);
    f_samp  += S_Sample_clk;
    f_done  += byte_done;
    f_abort += frame_abort;
    f_shift += S_Shift_clk;
    cyc++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      model_step();
    end
  endtask

  task automatic set_mode(input bit cpol, input bit cpha);
    rst_n = 1'b0;
    CPOL  = cpol;
    CPHA  = cpha;
    SCK   = cpol;
    SS_n  = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(4);
  endtask

  // kind: 0 normal, 1 SCK edge with SS_n rise, 2 reset held mid-frame, 3 gated
  task automatic run_frame(input int pulses, input int half, input int kind);
    string kname;
    int    e_s, e_d, e_a;
    f_samp = 0; f_done = 0; f_abort = 0; f_shift = 0;
    if (kind == 3) begin
      if ($urandom_range(0, 1) != 0) MSTR = 1'b1;
      else                           SPE  = 1'b0;
    end
    SS_n = 1'b0;
    tick(3 + $urandom_range(0, 2));
    for (int p = 0; p < pulses; p++) begin
      SCK = ~CPOL; tick(half);
      SCK = CPOL;  tick(half);
      if (kind == 2 && p == pulses / 2) rst_n = 1'b0;
    end
    tick(2);
    if (kind == 1) begin
      SS_n = 1'b1;
      SCK  = ~CPOL;
      tick(half);
      SCK  = CPOL;
    end else begin
      SS_n = 1'b1;
    end
    tick(SYNC + 4);
    // Stray SCK activity with the slave deselected.
    for (int p = 0; p < 2; p++) begin
      SCK = ~CPOL; tick(2);
      SCK = CPOL;  tick(2);
    end
    tick(2);
    case (kind)
      0: kname = "normal";
      1: kname = "sck_at_ss_rise";
      2: kname = "reset_mid";
      default: kname = "gated";
    endcase
    if (kind == 2) begin
      check("frm_abort_rst", f_abort, 0);
      rst_n = 1'b1;
      tick(3);
    end else if (kind == 3) begin
      check("frm_gated_samp", f_samp, 0);
      check("frm_gated_shift", f_shift, 0);
      MSTR = 1'b0;
      SPE  = 1'b1;
      tick(3);
    end else begin
      e_s = pulses;
      e_d = pulses / BITS;
      e_a = ((pulses % BITS) != 0) ? 1 : 0;
      check("frm_samples", f_samp, e_s);
      check("frm_bytes", f_done, e_d);
      check("frm_abort", f_abort, e_a);
    end
    $display("frame %0d cpol=%0d cpha=%0d pulses=%0d half=%0d kind=%s samples=%0d shifts=%0d bytes=%0d aborts=%0d",
             frame_no, CPOL, CPHA, pulses, half, kname, f_samp, f_shift, f_done, f_abort);
    frame_no++;
  endtask

  initial begin
    tick(6);
    check("rst_bitcnt", bit_cnt, 0);
    check("rst_baud", S_BaudRate, 0);
    rst_n = 1'b1;
    SPE   = 1'b1;
    tick(4);

    set_mode(1'b0, 1'b0);
    run_frame(8, 2, 0);
    run_frame(16, 3, 0);
    set_mode(1'b1, 1'b1);
    run_frame(8, 2, 0);
    set_mode(1'b0, 1'b0);
    run_frame(5, 3, 0);
    run_frame(5, 2, 1);
    run_frame(8, 2, 3);
    run_frame(6, 3, 2);

    for (int r = 0; r < 40; r++) begin
      set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_frame($urandom_range(1, 20), $urandom_range(2, 5), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
